clk_en_prescaler: RTL and testbench

//  Programmable clock-enable generator that drives the clkEn input of the 4-bit counter stage.
//  It divides clk by a runtime-loadable divisor and emits a one-cycle clkEn pulse every (div+1) clk cycles.
//  The divisor is reloaded through a valid/ready handshake. A new divisor takes effect only at a period

---
 rtl/clk_en_prescaler.sv | 144 ++++++++++++++
 tb/tb_clk_en_prescaler.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/clk_en_prescaler.sv
// clk_en_prescaler: programmable clock-enable generator for the 4-bit counter stage.
// Emits a one-cycle clkEn pulse every (div+1) clk cycles while en is high. A new
// divisor loaded through div_load/div_ready only takes effect at a period boundary,
// so no truncated or runt period is ever produced.
//
// Configuration macro: PRESCALER_SYNC_EN
//   defined   -> en passes through a 2-flop synchroniser (start/stop latency +2 cycles)
//   undefined -> en is used directly (must be in the clk domain)
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous reset, active-low
//   en         in   run request
//   div_load   in   divisor load valid
//   div_value  in   divisor to load (period = div_value+1)
//   div_ready  out  divisor load ready (low while a load is pending)
//   clkEn      out  one-cycle enable pulse
//   busy       out  high while not idle
module clk_en_prescaler #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DEFAULT_DIV = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             div_load,
  input  logic [WIDTH-1:0] div_value,
  output logic             div_ready,
  output logic             clkEn,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_div_q;
  logic [WIDTH-1:0] r_shd_q;

  logic w_en;
  logic w_load_acc;
  logic w_cnt_zero;

`ifdef PRESCALER_SYNC_EN
  // Two-flop synchroniser for an en coming from another clock domain.
  logic r_en_meta;
  logic r_en_sync;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_en_meta <= 1'b0;
      r_en_sync <= 1'b0;
    end else begin
      r_en_meta <= en;
      r_en_sync <= r_en_meta;
    end
  end

  assign w_en = r_en_sync;
`else
  assign w_en = en;
`endif

  assign w_load_acc = div_load && (r_state != PEND);
  assign w_cnt_zero = (r_cnt == '0);

  // Outputs are pure decodes of the state and counter flops.
  assign clkEn     = (r_state != IDLE) && w_cnt_zero;
  assign busy      = (r_state != IDLE);
  assign div_ready = (r_state != PEND);

  // Prescaler FSM, counter and divisor registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= WIDTH'(DEFAULT_DIV);
      r_div_q <= WIDTH'(DEFAULT_DIV);
      r_shd_q <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_load_acc) begin
            r_div_q <= div_value;
            r_cnt   <= div_value;
          end
          if (w_en) begin
            r_state <= RUN;
            r_cnt   <= w_load_acc ? div_value : r_div_q;
          end
        end

        RUN: begin
          if (!w_en) begin
            // Stopping: a load at the same edge still wins.
            r_state <= IDLE;
            if (w_load_acc) begin
              r_div_q <= div_value;
              r_cnt   <= div_value;
            end else begin
              r_cnt   <= r_div_q;
            end
          end else if (!w_cnt_zero) begin
            r_cnt <= r_cnt - WIDTH'(1);
            if (w_load_acc) begin
              r_shd_q <= div_value;
              r_state <= PEND;
            end
          end else begin
            // Pulse cycle is a period boundary: a load applies immediately.
            if (w_load_acc) begin
              r_div_q <= div_value;
              r_cnt   <= div_value;
            end else begin
              r_cnt   <= r_div_q;
            end
          end
        end

        PEND: begin
          if (!w_en) begin
            r_state <= IDLE;
            r_div_q <= r_shd_q;
            r_cnt   <= r_shd_q;
          end else if (!w_cnt_zero) begin
            r_cnt <= r_cnt - WIDTH'(1);
          end else begin
            r_state <= RUN;
            r_div_q <= r_shd_q;
            r_cnt   <= r_shd_q;
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_en_prescaler.sv
// Bench for clk_en_prescaler: directed scenarios with literal expectations plus a
// long randomized run, all checked every cycle against a period/phase model.
module tb_clk_en_prescaler;

`ifdef PRESCALER_SYNC_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       div_load;
  logic [7:0] div_value;
  logic       div_ready;
  logic       clkEn;
  logic       busy;

  clk_en_prescaler #(.WIDTH(8), .DEFAULT_DIV(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .div_load  (div_load),
    .div_value (div_value),
    .div_ready (div_ready),
    .clkEn     (clkEn),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  // Model: running flag, cycles elapsed in the current period, period divisor,
  // and an optional divisor waiting for the next period boundary.
  bit         m_run;
  bit         m_pend;
  int         m_phase;
  logic [7:0] m_div;
  logic [7:0] m_pdiv;
  logic       m_d1, m_d2;

  function automatic logic m_clken();
    return m_run && (m_phase == int'(m_div));
  endfunction

  task automatic model_reset();
    m_run = 0; m_pend = 0; m_phase = 0; m_div = 8'd3; m_pdiv = 8'd0;
    m_d1 = 1'b0; m_d2 = 1'b0;
  endtask

  task automatic model_update(input logic e, input logic ld, input logic [7:0] v);
    logic eff;
    bit   acc;
    eff = e;
`ifdef PRESCALER_SYNC_EN
    eff  = m_d2;
    m_d2 = m_d1;
    m_d1 = e;
`endif
    acc = ld && !m_pend;
    if (!m_run) begin
      if (acc) m_div = v;
      if (eff) begin m_run = 1; m_phase = 0; end
    end else if (!eff) begin
      m_run = 0;
      if (m_pend) m_div = m_pdiv;
      m_pend = 0;
      if (acc) m_div = v;
      m_phase = 0;
    end else if (m_phase == int'(m_div)) begin
      m_phase = 0;
      if (m_pend) begin m_div = m_pdiv; m_pend = 0; end
      else if (acc) m_div = v;
    end else begin
      m_phase++;
      if (acc) begin m_pend = 1; m_pdiv = v; end
    end
  endtask

  task automatic chk(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_clkEn", clkEn, m_clken());
      chk("model_busy", busy, m_run);
      chk("model_div_ready", div_ready, !m_pend);
    end
  end

  task automatic cyc(input logic e, input logic ld, input logic [7:0] v);
    en = e; div_load = ld; div_value = v;
    @(posedge clk);
    if (rst) model_update(e, ld, v);
    @(negedge clk);
  endtask

  // Asynchronous reset asserted between edges; outputs must react without a clock.
  task automatic do_reset();
    #2 rst = 1'b0;
    #1;
    chk("rst_clkEn", clkEn, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_div_ready", div_ready, 1'b1);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  logic [7:0] exp_clk [1:8];
  logic [7:0] exp_rdy [1:8];
  logic       en_r;

  initial begin
    rst = 1'b0; en = 1'b0; div_load = 1'b0; div_value = 8'd0;
    model_reset();
    #12;
    chk("init_clkEn", clkEn, 1'b0);
    chk("init_busy", busy, 1'b0);
    chk("init_div_ready", div_ready, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    chk_on = 1'b1;

    // Default divisor 3: pulse every 4th RUN cycle.
    for (int k = 1; k <= 16 + SL; k++) begin
      cyc(1'b1, 1'b0, 8'd0);
      chk("t2_clkEn", clkEn, (k > SL) && ((k - SL) % 4 == 0));
    end

    // Drop en while cnt==1: no further pulse, idle afterwards.
    for (int k = 1; k <= 3 - SL; k++) cyc(1'b1, 1'b0, 8'd0);
    for (int k = 1; k <= 1 + SL; k++) begin
      cyc(1'b0, 1'b0, 8'd0);
      chk("t5_no_pulse", clkEn, 1'b0);
    end
    chk("t5_busy", busy, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      cyc(1'b0, 1'b0, 8'd0);
      chk("t5_idle_clkEn", clkEn, 1'b0);
    end
    // Restart: full period before the first pulse.
    for (int k = 1; k <= 4 + SL; k++) begin
      cyc(1'b1, 1'b0, 8'd0);
      chk("t5_restart", clkEn, k == 4 + SL);
    end

    // Divisor 0 loaded in IDLE: pulse every cycle, ready stays high.
    for (int k = 1; k <= 4 + SL; k++) cyc(1'b0, 1'b0, 8'd0);
    cyc(1'b0, 1'b1, 8'd0);
    chk("t3_ready_load", div_ready, 1'b1);
    for (int k = 1; k <= 6 + SL; k++) begin
      cyc(1'b1, 1'b0, 8'd0);
      chk("t3_clkEn", clkEn, k > SL);
      chk("t3_ready", div_ready, 1'b1);
    end

    // Divisor 3 running, load 1 at cnt==2: pending until the next pulse.
    for (int k = 1; k <= 4 + SL; k++) cyc(1'b0, 1'b0, 8'd0);
    cyc(1'b0, 1'b1, 8'd3);
    exp_clk = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd1, 8'd0, 8'd1};
    exp_rdy = '{8'd1, 8'd1, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd1};
    for (int k = 1; k <= 8 + SL; k++) begin
      cyc(1'b1, k == 3 + SL, 8'd1);
      if (k > SL) begin
        chk("t4_clkEn", clkEn, exp_clk[k - SL][0]);
        chk("t4_ready", div_ready, exp_rdy[k - SL][0]);
      end
    end

    // Load in the pulse cycle: new period of 3 starts at once, no pending state.
    for (int k = 1; k <= 6; k++) begin
      cyc(1'b1, k == 1, 8'd2);
      chk("t6_clkEn", clkEn, (k == 3) || (k == 6));
      chk("t6_ready", div_ready, 1'b1);
    end

    do_reset();

    // Randomized run with occasional mid-cycle resets.
    en_r = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      logic       ld;
      logic [7:0] v;
      if ($urandom_range(0, 15) == 0) en_r = ~en_r;
      ld = ($urandom_range(0, 4) == 0);
      v  = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 40)) : 8'($urandom_range(0, 6));
      cyc(en_r, ld, v);
      if ($urandom_range(0, 399) == 0) do_reset();
    end

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
